weight_load_ctrl: RTL and testbench
===================================

// Module: weight_load_ctrl
// PURPOSE
//  Transmit side of the PE weight-buffer flush interface: fetches kernels from the on-chip weight BRAM
//  and streams them into one or more PE weight buffers. Per PE: one-cycle flush pulse, then exactly
//  kernel_size consecutive words on a shared data bus. Sits between the command/DMA layer and the PE array.
// PARAMETERS
//  DATA_WIDTH    16   weight word width; matches the PE weight buffer
//  BUFFER_DEPTH  16   PE weight buffer depth; largest legal kernel_size
//  NUM_PE        8    number of PE weight buffers driven
//  ADDR_WIDTH    12   weight BRAM word-address width
// PORTS
//  clk             in   1                  system clock
//  rstn            in   1                  async active-low reset
//  cmd_valid       in   1                  load command valid
//  cmd_ready       out  1                  command accepted when valid&ready
//  cmd_base_addr   in   ADDR_WIDTH         BRAM address of the first word
//  cmd_kernel_size in   8                  words per PE (K)
//  cmd_pe_start    in   $clog2(NUM_PE)     first PE to load
//  cmd_pe_count    in   $clog2(NUM_PE)+1   number of consecutive PEs (N)
//  mem_rd_en       out  1                  BRAM read enable
//  mem_addr        out  ADDR_WIDTH         BRAM read address
//  mem_rdata       in   DATA_WIDTH         BRAM data; fixed 1-cycle latency after mem_rd_en
//  flush           out  NUM_PE             per-PE flush pulse; one-hot or zero
//  data_out        out  DATA_WIDTH         shared weight bus; combinational copy of mem_rdata
//  data_valid      out  1                  data_out carries a weight word this cycle
//  busy            out  1                  command in progress (state != IDLE)
//  done            out  1                  one-cycle pulse when the command completes
//  err             out  1                  sticky illegal-command flag; cleared only by reset
// BEHAVIOUR
//  - Reset: all outputs 0 except cmd_ready=1. State IDLE. Counters and latched command cleared.
//  - FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE. cmd_ready=1 only in IDLE.
//  - Accept at cycle a (IDLE, cmd_valid=1): latch all cmd fields; go to ISSUE at a+1.
//  - ISSUE runs for N*K cycles, a+1..a+N*K.
//    - Each cycle: mem_rd_en=1; mem_addr = base + i, where i = 0..N*K-1.
//    - When i%K==0: flush[pe_start + i/K] = 1.
//    - Flush for PE j+1 coincides with the last data word of PE j. Legal because the buffers differ.
//  - mem_rdata is returned 1 cycle later. data_valid=1 on cycles a+2..a+N*K+1.
//    - The buffer enters its write state the cycle after flush, so word w of PE j lands in entry w.
//  - DRAIN (1 cycle, a+N*K+1): last data word on the bus; no reads issued.
//  - DONE (a+N*K+2): done=1; back to IDLE at a+N*K+3. Total latency accept->done = N*K+2 cycles.
//  - Address arithmetic wraps modulo 2^ADDR_WIDTH; the wrap is not flagged.
//  - Counters: word-in-kernel (0..K-1) and PE index (0..N-1). Compare against K-1 and N-1 at full width.
//  - Illegal command = any of:
//    - K==0 or K>BUFFER_DEPTH
//    - N==0
//    - pe_start+N > NUM_PE
//  - On an illegal command: accepted as normal (one cycle); err set; no flush, no reads.
//    DONE is entered directly, so done pulses at a+1.
//  - data_valid=0 => data_out is don't-care; the bench must not check it.
//  - cmd_valid while busy: ignored, no queueing. Command fields may change freely while busy.
//  - Async reset mid-command: flush, mem_rd_en and data_valid drop immediately.
//    A partially loaded PE buffer is left to its own reset; no resume.
// STRUCTURE
//  - Package wload_pkg holds:
//    - FSM state localparams (IDLE/ISSUE/DRAIN/DONE, 2 bits)
//    - the BUFFER_DEPTH default
//    - the function that builds the one-hot flush vector from a PE index
//  - Sub-module wload_addr_gen: base/word/PE counters. Outputs mem_addr, kernel_last, pe_first_word, all_last.
//    Top holds the FSM, the command latch and the output gating.
// TESTING
//  1. Reset, then K=3, N=1, pe_start=2, base=0x010 accepted at cycle 0:
//     - flush=8'b0000_0100 at cycle 1 only
//     - mem_addr 0x010..0x012 at cycles 1-3
//     - data_valid at cycles 2-4
//     - done at cycle 5
//  2. K=4, N=3, pe_start=0:
//     - flush bits 0/1/2 at cycles 1/5/9
//     - 12 contiguous addresses
//     - PE1 buffer holds words 4..7 in entries 0..3
//     - done at cycle 14
//  3. Illegal commands, each separately (K=0; K=17; N=0; pe_start=6,N=3):
//     - err=1, done at cycle 1
//     - flush never asserted, mem_rd_en stays 0
//  4. K=16=BUFFER_DEPTH, base=0xFFE (ADDR_WIDTH=12): addresses wrap 0xFFE, 0xFFF, 0x000..0x00D; no err.
//  5. cmd_valid held high through the whole command:
//     - second command accepted exactly the cycle after done
//     - cmd_ready low throughout busy
//  6. rstn asserted at cycle 3 of a K=8, N=2 load:
//     - flush, mem_rd_en, data_valid, busy drop at once; cmd_ready=1
//     - a fresh command after reset completes normally

Source files
------------

// File: rtl/wload_pkg.sv
// Shared types and helpers for the PE weight-buffer load controller.
package wload_pkg;

  localparam int BUFFER_DEPTH_DEF = 16;
  localparam int FLUSH_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One-hot PE select; callers truncate to their own PE count.
  function automatic logic [FLUSH_W-1:0] pe_onehot(input logic [7:0] idx);
    return FLUSH_W'(1) << idx;
  endfunction

endpackage

// File: rtl/wload_addr_gen.sv
// Address, word-in-kernel and PE counters for a weight load sweep.
module wload_addr_gen #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            kernel_size,
  input  logic [CNT_W-1:0]      pe_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [CNT_W-1:0]      pe_index,
  output logic                  kernel_last,
  output logic                  pe_first_word,
  output logic                  all_last
);

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            word_q;
  logic [CNT_W-1:0]      pe_q;

  // Sizes are only consulted while a legal command is issuing, so K>=1 and N>=1 here.
  assign kernel_last   = (word_q == kernel_size - 8'd1);
  assign pe_first_word = (word_q == 8'd0);
  assign all_last      = kernel_last && (pe_q == pe_count - CNT_W'(1));
  assign mem_addr      = addr_q;
  assign pe_index      = pe_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      word_q <= '0;
      pe_q   <= '0;
    end else if (load) begin
      addr_q <= base_addr;
      word_q <= '0;
      pe_q   <= '0;
    end else if (advance) begin
      addr_q <= addr_q + ADDR_WIDTH'(1);
      if (kernel_last) begin
        word_q <= '0;
        pe_q   <= pe_q + CNT_W'(1);
      end else begin
        word_q <= word_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/weight_load_ctrl.sv
// Streams kernels from the weight BRAM into consecutive PE weight buffers:
// one flush pulse per PE followed by K words on the shared data bus.
module weight_load_ctrl
  import wload_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int BUFFER_DEPTH = BUFFER_DEPTH_DEF,
  parameter int NUM_PE       = 8,
  parameter int ADDR_WIDTH   = 12,
  localparam int PE_W        = $clog2(NUM_PE),
  localparam int CNT_W       = PE_W + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [7:0]            cmd_kernel_size,
  input  logic [PE_W-1:0]       cmd_pe_start,
  input  logic [CNT_W-1:0]      cmd_pe_count,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [NUM_PE-1:0]     flush,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t           state, state_next;
  logic [7:0]       kernel_q;
  logic [PE_W-1:0]  start_q;
  logic [CNT_W-1:0] count_q;
  logic             data_valid_q;
  logic             accept, illegal;
  logic             kernel_last, pe_first_word, all_last;
  logic [CNT_W-1:0] pe_index, flush_idx;

  assign accept  = (state == ST_IDLE) && cmd_valid;
  assign illegal = (cmd_kernel_size == 8'd0)
                || (int'(cmd_kernel_size) > BUFFER_DEPTH)
                || (cmd_pe_count == '0)
                || (int'(cmd_pe_start) + int'(cmd_pe_count) > NUM_PE);

  wload_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_W      (CNT_W)
  ) u_addr_gen (
    .clk           (clk),
    .rstn          (rstn),
    .load          (accept),
    .advance       (state == ST_ISSUE),
    .base_addr     (cmd_base_addr),
    .kernel_size   (kernel_q),
    .pe_count      (count_q),
    .mem_addr      (mem_addr),
    .pe_index      (pe_index),
    .kernel_last   (kernel_last),
    .pe_first_word (pe_first_word),
    .all_last      (all_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      kernel_q     <= '0;
      start_q      <= '0;
      count_q      <= '0;
      err          <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state        <= state_next;
      data_valid_q <= mem_rd_en;
      if (accept) begin
        kernel_q <= cmd_kernel_size;
        start_q  <= cmd_pe_start;
        count_q  <= cmd_pe_count;
        if (illegal) err <= 1'b1;
      end
    end
  end

  // An illegal command skips straight to DONE so the requester still sees completion.
  always_comb begin
    state_next = state;
    mem_rd_en  = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE:  if (cmd_valid) state_next = illegal ? ST_DONE : ST_ISSUE;
      ST_ISSUE: begin
        mem_rd_en = 1'b1;
        if (all_last) state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  assign flush_idx  = CNT_W'(start_q) + pe_index;
  assign flush      = ((state == ST_ISSUE) && pe_first_word)
                      ? NUM_PE'(pe_onehot(8'(flush_idx))) : '0;
  assign data_out   = mem_rdata;
  assign data_valid = data_valid_q;
  assign busy       = (state != ST_IDLE);
  assign cmd_ready  = (state == ST_IDLE);

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: BRAM model, PE buffer model and per-cycle reference.
module tb_weight_load_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_base_addr;
  logic [7:0]  cmd_kernel_size;
  logic [2:0]  cmd_pe_start;
  logic [3:0]  cmd_pe_count;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [7:0]  flush;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit exp_err = 1'b0;

  logic [15:0] mem [4096];
  logic [15:0] rd_next = '0;
  logic [15:0] pbuf [8][16];
  int          cur_pe = -1;
  int          wptr = 0;

  weight_load_ctrl dut (
    .clk             (clk),
    .rstn            (rstn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_base_addr   (cmd_base_addr),
    .cmd_kernel_size (cmd_kernel_size),
    .cmd_pe_start    (cmd_pe_start),
    .cmd_pe_count    (cmd_pe_count),
    .mem_rd_en       (mem_rd_en),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .flush           (flush),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  always #5 clk = ~clk;

  // BRAM: request seen mid-cycle, data presented one cycle later.
  always @(negedge clk) if (mem_rd_en) rd_next <= mem[mem_addr];
  always @(posedge clk) mem_rdata <= rd_next;

  // PE buffers: flush points the write pointer at entry 0; words land from the next cycle.
  always @(negedge clk) begin
    if (!rstn) begin
      cur_pe <= -1;
      wptr   <= 0;
    end else begin
      if (data_valid && cur_pe >= 0 && wptr < 16) begin
        pbuf[cur_pe][wptr] <= data_out;
        wptr <= wptr + 1;
      end
      for (int j = 0; j < 8; j++) begin
        if (flush[j]) begin
          cur_pe <= j;
          wptr   <= 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command in the current (idle) cycle and check every cycle until idle again.
  task automatic run_cmd(input logic [11:0] base, input int k, input int start,
                         input int n, input bit hold);
    bit         ill;
    int         nk, last;
    bit         e_rd, e_dv, e_done, e_busy;
    logic [7:0] e_fl;
    ill  = (k == 0) || (k > 16) || (n == 0) || (start + n > 8);
    nk   = n * k;
    last = ill ? 2 : nk + 3;
    check($sformatf("k%0d n%0d c0 cmd_ready", k, n), 32'(cmd_ready), 32'd1);
    cmd_valid       = 1'b1;
    cmd_base_addr   = base;
    cmd_kernel_size = 8'(k);
    cmd_pe_start    = 3'(start);
    cmd_pe_count    = 4'(n);
    if (ill) exp_err = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (ill) begin
        e_rd = 0; e_dv = 0; e_fl = '0;
        e_done = (c == 1);
        e_busy = (c == 1);
      end else begin
        e_rd   = (c <= nk);
        e_dv   = (c >= 2) && (c <= nk + 1);
        e_done = (c == nk + 2);
        e_busy = (c <= nk + 2);
        e_fl   = (e_rd && ((c - 1) % k == 0)) ? 8'(32'd1 << (start + (c - 1) / k)) : 8'd0;
      end
      check($sformatf("k%0d n%0d c%0d mem_rd_en", k, n, c), 32'(mem_rd_en), 32'(e_rd));
      check($sformatf("k%0d n%0d c%0d flush", k, n, c), 32'(flush), 32'(e_fl));
      check($sformatf("k%0d n%0d c%0d data_valid", k, n, c), 32'(data_valid), 32'(e_dv));
      check($sformatf("k%0d n%0d c%0d done", k, n, c), 32'(done), 32'(e_done));
      check($sformatf("k%0d n%0d c%0d busy", k, n, c), 32'(busy), 32'(e_busy));
      check($sformatf("k%0d n%0d c%0d cmd_ready", k, n, c), 32'(cmd_ready), 32'(!e_busy));
      check($sformatf("k%0d n%0d c%0d err", k, n, c), 32'(err), 32'(exp_err));
      if (e_rd)
        check($sformatf("k%0d n%0d c%0d mem_addr", k, n, c), 32'(mem_addr), 32'(12'(base + c - 1)));
      if (e_dv)
        check($sformatf("k%0d n%0d c%0d data_out", k, n, c), 32'(data_out),
              32'(mem[12'(base + c - 2)]));
      if (!hold) begin
        if (c < last) begin
          cmd_valid       = 1'($urandom);
          cmd_base_addr   = 12'($urandom);
          cmd_kernel_size = 8'($urandom);
          cmd_pe_start    = 3'($urandom);
          cmd_pe_count    = 4'($urandom);
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] b;
    int          n, s;
    rstn            = 1'b0;
    cmd_valid       = 1'b0;
    cmd_base_addr   = '0;
    cmd_kernel_size = '0;
    cmd_pe_start    = '0;
    cmd_pe_count    = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset flush", 32'(flush), 32'd0);
    check("reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check("reset data_valid", 32'(data_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_cmd(12'h010, 3, 2, 1, 1'b0);

    b = 12'h2A0;
    run_cmd(b, 4, 0, 3, 1'b0);
    for (int w = 0; w < 4; w++) begin
      check($sformatf("pe1 entry%0d", w), 32'(pbuf[1][w]), 32'(mem[12'(b + 4 + w)]));
      check($sformatf("pe2 entry%0d", w), 32'(pbuf[2][w]), 32'(mem[12'(b + 8 + w)]));
    end

    run_cmd(12'hFFE, 16, 3, 1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      s = $urandom_range(0, 8 - n);
      run_cmd(12'($urandom), $urandom_range(1, 16), s, n, 1'b0);
    end

    run_cmd(12'h100, 2, 1, 2, 1'b1);
    run_cmd(12'h100, 2, 1, 2, 1'b0);

    run_cmd(12'h040, 0, 0, 1, 1'b0);
    run_cmd(12'h040, 17, 0, 1, 1'b0);
    run_cmd(12'h040, 4, 0, 0, 1'b0);
    run_cmd(12'h040, 2, 6, 3, 1'b0);

    cmd_valid       = 1'b1;
    cmd_base_addr   = 12'h300;
    cmd_kernel_size = 8'd8;
    cmd_pe_start    = 3'd1;
    cmd_pe_count    = 4'd2;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("pre-reset c3 mem_rd_en", 32'(mem_rd_en), 32'd1);
    check("pre-reset c3 data_valid", 32'(data_valid), 32'd1);
    rstn = 1'b0;
    #1;
    exp_err = 1'b0;
    check("mid reset flush", 32'(flush), 32'd0);
    check("mid reset mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("mid reset data_valid", 32'(data_valid), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid reset err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    run_cmd(12'h500, 8, 1, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
